// File: rtl/wb_host_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// wb_host_arbiter_pkg
// Shared definitions for the mainboard Wishbone host arbiter. It holds the
// arbiter FSM state encoding, the 8-bit window IDs carried in adr[0:7], the
// read data returned on a watchdog termination, and the one-hot owner codes.
// ----------------------------------------------------------------------------
package wb_host_arbiter_pkg;

    // Arbiter states: idle, or bus locked to master 0 / master 1
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT0 = 2'd1,
        ST_GRANT1 = 2'd2
    } arbState_e;

    // Mainboard windows selected by adr[0:7]; anything above CROM_LAST is unmapped
    localparam logic [7:0] WB_WIN_VDP        = 8'h00;
    localparam logic [7:0] WB_WIN_ROM        = 8'h01;
    localparam logic [7:0] WB_WIN_GROM       = 8'h02;
    localparam logic [7:0] WB_WIN_CROM_FIRST = 8'h03;
    localparam logic [7:0] WB_WIN_CROM_LAST  = 8'h05;

    // Read data presented to the owner on the cycle its access is timed out
    localparam logic [7:0] TIMEOUT_ERR_DATA  = 8'hff;

    // One-hot owner encoding {m0,m1}
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_M0   = 2'b10;
    localparam logic [1:0] OWNER_M1   = 2'b01;

    // True when the window ID lands on a region the mainboard will acknowledge
    function automatic logic isMappedWindow(input logic [7:0] win);
        return (win <= WB_WIN_CROM_LAST);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// ----------------------------------------------------------------------------
// wb_watchdog
// Counts consecutive cycles in which the slave strobe is high without an
// acknowledge. On the TIMEOUT_CYCLES-th such cycle it raises o_errCycle for
// exactly one following cycle, which the arbiter uses to end the access.
//
// Ports
//   clk            in   system clock
//   reset_n        in   asynchronous reset, active low
//   i_stb          in   strobe as presented to the slave (already gated)
//   i_ack          in   slave acknowledge
//   i_grantChange  in   arbiter grant is changing at the next edge
//   o_errCycle     out  one-cycle timeout termination pulse
// ----------------------------------------------------------------------------
module wb_watchdog #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_stb,
    input  logic i_ack,
    input  logic i_grantChange,
    output logic o_errCycle
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          r_errCycle;
    logic          w_clear;

    // An ack always wins over a timeout: an acked cycle clears instead of firing.
    // The err cycle itself drives i_stb low, so the counter restarts from zero.
    assign w_clear = ~i_stb | i_ack | i_grantChange;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count    <= '0;
            r_errCycle <= 1'b0;
        end else begin
            r_errCycle <= 1'b0;
            if (w_clear) begin
                r_count <= '0;
            end else if (r_count == LAST_COUNT) begin
                r_count    <= '0;
                r_errCycle <= 1'b1;
            end else begin
                r_count <= r_count + CW'(1);
            end
        end
    end

    assign o_errCycle = r_errCycle;

endmodule

// File: rtl/wb_host_arbiter.sv
// ----------------------------------------------------------------------------
// wb_host_arbiter
// Shares the mainboard 8-bit Wishbone configuration/debug port between the
// host loader (m0) and the debug monitor (m1). Arbitration is round-robin and
// transaction-locked: a granted master keeps the bus for as long as it holds
// cyc. A watchdog ends strobes the mainboard never acknowledges (unmapped
// windows) with a one-cycle err and read data 8'hff.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   mN_adr_i/dat_i/we_i/sel_i    master N request (N = 0, 1)
//   mN_stb_i, mN_cyc_i           master N strobe and bus request/lock
//   mN_dat_o, mN_ack_o, mN_err_o master N read data and terminations
//   s_adr_o/dat_o/we_o/sel_o     muxed request to the mainboard
//   s_stb_o, s_cyc_o             muxed strobe/cycle to the mainboard
//   s_dat_i, s_ack_i             mainboard read data and acknowledge
//   owner                        one-hot grant {m0,m1}, 2'b00 when idle
// ----------------------------------------------------------------------------
module wb_host_arbiter
    import wb_host_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ADR_BITS       = 24
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [0:ADR_BITS-1]   m0_adr_i,
    input  logic [7:0]            m0_dat_i,
    output logic [7:0]            m0_dat_o,
    input  logic                  m0_we_i,
    input  logic                  m0_sel_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_cyc_i,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,

    input  logic [0:ADR_BITS-1]   m1_adr_i,
    input  logic [7:0]            m1_dat_i,
    output logic [7:0]            m1_dat_o,
    input  logic                  m1_we_i,
    input  logic                  m1_sel_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_cyc_i,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,

    output logic [0:ADR_BITS-1]   s_adr_o,
    output logic [7:0]            s_dat_o,
    input  logic [7:0]            s_dat_i,
    output logic                  s_we_o,
    output logic                  s_sel_o,
    output logic                  s_stb_o,
    output logic                  s_cyc_o,
    input  logic                  s_ack_i,

    output logic [1:0]            owner
);

    arbState_e r_state;
    arbState_e w_stateNext;
    logic      r_lastOwner;      // 0 = m0 last held the bus, 1 = m1
    logic      w_lastOwnerNext;
    logic      w_grantChange;
    logic      w_errCycle;

    // State register; last owner resets to m1 so m0 wins the first tie
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_lastOwner <= 1'b1;
        end else begin
            r_state     <= w_stateNext;
            r_lastOwner <= w_lastOwnerNext;
        end
    end

    // Next-state: arbitrate only from IDLE, so releasing the bus always costs
    // one idle cycle and the new grant appears one cycle after that
    always_comb begin
        w_stateNext     = r_state;
        w_lastOwnerNext = r_lastOwner;
        case (r_state)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_stateNext = r_lastOwner ? ST_GRANT0 : ST_GRANT1;
                end else if (m0_cyc_i) begin
                    w_stateNext = ST_GRANT0;
                end else if (m1_cyc_i) begin
                    w_stateNext = ST_GRANT1;
                end
            end
            ST_GRANT0: begin
                if (!m0_cyc_i) begin
                    w_stateNext     = ST_IDLE;
                    w_lastOwnerNext = 1'b0;
                end
            end
            ST_GRANT1: begin
                if (!m1_cyc_i) begin
                    w_stateNext     = ST_IDLE;
                    w_lastOwnerNext = 1'b1;
                end
            end
            default: w_stateNext = ST_IDLE;
        endcase
    end

    assign w_grantChange = (w_stateNext != r_state);

    // Owner decode straight from the registered state so it never glitches
    always_comb begin
        owner = OWNER_NONE;
        case (r_state)
            ST_GRANT0: owner = OWNER_M0;
            ST_GRANT1: owner = OWNER_M1;
            default:   owner = OWNER_NONE;
        endcase
    end

    // Slave-side mux; the strobe is masked during the timeout err cycle
    always_comb begin
        s_adr_o = '0;
        s_dat_o = 8'h00;
        s_we_o  = 1'b0;
        s_sel_o = 1'b0;
        s_stb_o = 1'b0;
        s_cyc_o = 1'b0;
        if (owner[1]) begin
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_stb_o = m0_stb_i & ~w_errCycle;
            s_cyc_o = m0_cyc_i;
        end else if (owner[0]) begin
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_stb_o = m1_stb_i & ~w_errCycle;
            s_cyc_o = m1_cyc_i;
        end
    end

    wb_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk           (clk),
        .reset_n       (reset_n),
        .i_stb         (s_stb_o),
        .i_ack         (s_ack_i),
        .i_grantChange (w_grantChange),
        .o_errCycle    (w_errCycle)
    );

    // Return path: only the owner ever sees ack, err or slave data
    assign m0_ack_o = owner[1] & s_ack_i;
    assign m1_ack_o = owner[0] & s_ack_i;
    assign m0_err_o = owner[1] & w_errCycle;
    assign m1_err_o = owner[0] & w_errCycle;
    assign m0_dat_o = owner[1] ? (w_errCycle ? TIMEOUT_ERR_DATA : s_dat_i) : 8'h00;
    assign m1_dat_o = owner[0] ? (w_errCycle ? TIMEOUT_ERR_DATA : s_dat_i) : 8'h00;

endmodule
